// File: rtl/stack_packetizer_pkg.sv
// Shared types and constants for the geiger stack packetizer.
// Optional feature macro: STACK_PKT_CHECKSUM_EN (appends a checksum byte to each frame).
package stack_pkt_pkg;

    // Width of one geiger data stack: {counts[15:0], timestamp[23:0], id[7:0]}
    localparam int STACK_W    = 48;
    localparam int DATA_BYTES = STACK_W / 8;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hAA;

`ifdef STACK_PKT_CHECKSUM_EN
    // Sync byte, six data bytes, checksum byte
    localparam int FRAME_BYTES = DATA_BYTES + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2,
        CSUM = 2'd3
    } state_t;
`else
    // Sync byte followed by six data bytes
    localparam int FRAME_BYTES = DATA_BYTES + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2
    } state_t;
`endif

    // Data byte idx of a stack, most significant byte first
    function automatic logic [7:0] frame_byte(input logic [STACK_W-1:0] frame,
                                              input logic [2:0]         idx);
        return frame[STACK_W - 1 - 8 * int'(idx) -: 8];
    endfunction

endpackage

// File: rtl/stack_packetizer_if.sv
// Stack input, byte-stream output and status signals of the stack packetizer.
// master: the packetizer itself; slave: whoever supplies stacks and drains bytes.
interface stack_packetizer_if #(
    parameter int DEPTH = 4
);
    import stack_pkt_pkg::*;

    localparam int LEVEL_W = $clog2(DEPTH) + 1;

    logic [STACK_W-1:0] STACK_IN;
    logic               STACK_VALID;
    logic [7:0]         TX_BYTE;
    logic               TX_VALID;
    logic               TX_READY;
    logic               BUSY;
    logic [LEVEL_W-1:0] FIFO_LEVEL;
    logic               OVERFLOW;
    logic [7:0]         DROP_COUNT;

    modport master (
        input  STACK_IN, STACK_VALID, TX_READY,
        output TX_BYTE, TX_VALID, BUSY, FIFO_LEVEL, OVERFLOW, DROP_COUNT
    );

    modport slave (
        output STACK_IN, STACK_VALID, TX_READY,
        input  TX_BYTE, TX_VALID, BUSY, FIFO_LEVEL, OVERFLOW, DROP_COUNT
    );

endinterface

// File: rtl/stack_packetizer_fifo.sv
// First-word-fall-through FIFO of data stacks. DEPTH must be a power of two, >= 2.
// Pointers carry one extra wrap bit: equal means empty, differing only in the
// wrap bit means full.
module stack_fifo
    import stack_pkt_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = STACK_W
) (
    input  logic                     CLK_1MHZ,
    input  logic                     RESET,
    input  logic                     push,
    input  logic [W-1:0]             wr_data,
    input  logic                     pop,
    output logic [W-1:0]             rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level   = wr_ptr - rd_ptr;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Advance the pointers on push and pop; both may happen in one cycle
    always_ff @(posedge CLK_1MHZ or posedge RESET) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Store pushed stacks
    always_ff @(posedge CLK_1MHZ) begin
        // NOTE: storage is deliberately not reset; the pointers alone define
        // which entries are valid, and an unreset array maps onto plain RAM.
        if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/stack_packetizer.sv
// Buffers 48-bit geiger stacks and serializes each one as a framed byte stream
// (sync byte, six data bytes MSB first, optional checksum) on a valid/ready
// byte interface. Stacks arriving with the FIFO full and no pop are dropped
// and counted.
// Optional feature macro: STACK_PKT_CHECKSUM_EN (adds the CSUM state and byte).
module stack_packetizer
    import stack_pkt_pkg::*;
#(
    parameter int         DEPTH     = 4,
    parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
    input  logic          CLK_1MHZ,
    input  logic          RESET,
    stack_packetizer_if.master bus
);

    localparam int          LEVEL_W   = $clog2(DEPTH) + 1;
    localparam logic [2:0]  LAST_BYTE = 3'(DATA_BYTES - 1);

    state_t             state;
    logic [STACK_W-1:0] frame;
    logic [2:0]         byte_idx;
    logic [7:0]         tx_byte;
    logic               tx_valid;
    logic               overflow;
    logic [7:0]         drop_count;
`ifdef STACK_PKT_CHECKSUM_EN
    logic [7:0]         csum;
`endif

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [STACK_W-1:0] fifo_rd_data;
    logic [LEVEL_W-1:0] fifo_level;
    logic               drop;
    logic               handshake;

    // The FSM pops whenever it sits in IDLE with something queued. A pop frees
    // a slot on the same edge, so a strobe into a full FIFO is only dropped
    // when no pop coincides with it.
    assign fifo_pop  = (state == IDLE) && !fifo_empty;
    assign fifo_push = bus.STACK_VALID && (!fifo_full || fifo_pop);
    assign drop      = bus.STACK_VALID && fifo_full && !fifo_pop;
    assign handshake = tx_valid && bus.TX_READY;

    stack_fifo #(
        .DEPTH (DEPTH),
        .W     (STACK_W)
    ) u_fifo (
        .CLK_1MHZ (CLK_1MHZ),
        .RESET    (RESET),
        .push     (fifo_push),
        .wr_data  (bus.STACK_IN),
        .pop      (fifo_pop),
        .rd_data  (fifo_rd_data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    // Frame FSM: TX_BYTE/TX_VALID are registered and only change on a
    // handshake, so they hold steady through any downlink stall
    always_ff @(posedge CLK_1MHZ or posedge RESET) begin
        if (RESET) begin
            state    <= IDLE;
            frame    <= '0;
            byte_idx <= '0;
            tx_byte  <= '0;
            tx_valid <= 1'b0;
`ifdef STACK_PKT_CHECKSUM_EN
            csum     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (fifo_pop) begin
                        frame    <= fifo_rd_data;
                        tx_byte  <= SYNC_BYTE;
                        tx_valid <= 1'b1;
                        state    <= SYNC;
`ifdef STACK_PKT_CHECKSUM_EN
                        csum     <= '0;
`endif
                    end
                end

                SYNC: begin
                    if (handshake) begin
                        byte_idx <= '0;
                        tx_byte  <= frame_byte(frame, 3'd0);
                        state    <= DATA;
                    end
                end

                DATA: begin
                    if (handshake) begin
`ifdef STACK_PKT_CHECKSUM_EN
                        // tx_byte is the byte just transferred
                        csum <= csum + tx_byte;
`endif
                        if (byte_idx == LAST_BYTE) begin
`ifdef STACK_PKT_CHECKSUM_EN
                            tx_byte <= csum + tx_byte;
                            state   <= CSUM;
`else
                            tx_byte  <= '0;
                            tx_valid <= 1'b0;
                            state    <= IDLE;
`endif
                        end else begin
                            byte_idx <= byte_idx + 3'd1;
                            tx_byte  <= frame_byte(frame, byte_idx + 3'd1);
                        end
                    end
                end

`ifdef STACK_PKT_CHECKSUM_EN
                CSUM: begin
                    if (handshake) begin
                        tx_byte  <= '0;
                        tx_valid <= 1'b0;
                        state    <= IDLE;
                    end
                end
`endif

                default: begin
                    tx_byte  <= '0;
                    tx_valid <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    // Sticky overflow flag and saturating drop counter
    always_ff @(posedge CLK_1MHZ or posedge RESET) begin
        if (RESET) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
        end
    end

    assign bus.TX_BYTE    = tx_byte;
    assign bus.TX_VALID   = tx_valid;
    assign bus.BUSY       = (state != IDLE);
    assign bus.FIFO_LEVEL = fifo_level;
    assign bus.OVERFLOW   = overflow;
    assign bus.DROP_COUNT = drop_count;

endmodule

// File: tb/tb_stack_packetizer.sv
// Self-checking bench for stack_packetizer. Works with or without
// STACK_PKT_CHECKSUM_EN; the expected frame length follows the same macro.
`timescale 1ns/1ps
module tb_stack_packetizer;

    localparam int DEPTH = 4;
`ifdef STACK_PKT_CHECKSUM_EN
    localparam int FLEN = 8;
`else
    localparam int FLEN = 7;
`endif

    logic CLK_1MHZ = 1'b0;
    logic RESET    = 1'b1;

    stack_packetizer_if #(.DEPTH(DEPTH)) bus ();

    stack_packetizer #(
        .DEPTH     (DEPTH),
        .SYNC_BYTE (8'hAA)
    ) dut (
        .CLK_1MHZ (CLK_1MHZ),
        .RESET    (RESET),
        .bus      (bus)
    );

    always #500 CLK_1MHZ = ~CLK_1MHZ;

    int total = 0;
    int bad   = 0;

    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    logic       stall_prev;
    logic [7:0] stall_byte;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Capture every transferred byte; while stalled, the offered byte must hold
    always @(posedge CLK_1MHZ or posedge RESET) begin
        if (RESET) begin
            stall_prev <= 1'b0;
            stall_byte <= 8'h00;
        end else begin
            if (stall_prev) begin
                check("hold_valid", 64'(bus.TX_VALID), 64'(1'b1));
                check("hold_byte",  64'(bus.TX_BYTE),  64'(stall_byte));
            end
            if (bus.TX_VALID && bus.TX_READY) got.push_back(bus.TX_BYTE);
            stall_prev <= bus.TX_VALID && !bus.TX_READY;
            stall_byte <= bus.TX_BYTE;
        end
    end

    // Reference framing: sync, six bytes MSB first, optional mod-256 sum
    task automatic expect_frame(input logic [47:0] stack);
        logic [7:0] b;
        int         sum;
        sum = 0;
        exp_q.push_back(8'hAA);
        for (int i = 0; i < 6; i++) begin
            b = 8'((stack >> (40 - 8 * i)) & 48'hFF);
            exp_q.push_back(b);
            sum = sum + int'(b);
        end
`ifdef STACK_PKT_CHECKSUM_EN
        exp_q.push_back(8'(sum % 256));
`endif
    endtask

    task automatic compare_stream(input string tag);
        int n;
        check({tag, "_len"}, 64'(got.size()), 64'(exp_q.size()));
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_byte%0d", tag, i), 64'(got[i]), 64'(exp_q[i]));
        got.delete();
        exp_q.delete();
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while ((bus.BUSY || bus.TX_VALID || bus.FIFO_LEVEL != 0) && n < budget) begin
            @(negedge CLK_1MHZ);
            n++;
        end
        check({tag, "_drain_in_time"}, 64'(n < budget), 64'(1'b1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_valid"}, 64'(bus.TX_VALID),   64'(0));
        check({tag, "_tx_byte"},  64'(bus.TX_BYTE),    64'(0));
        check({tag, "_busy"},     64'(bus.BUSY),       64'(0));
        check({tag, "_level"},    64'(bus.FIFO_LEVEL), 64'(0));
        check({tag, "_overflow"}, 64'(bus.OVERFLOW),   64'(0));
        check({tag, "_drops"},    64'(bus.DROP_COUNT), 64'(0));
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] s;
        logic [47:0] burst[7];
        int          n;
        int          k;

        bus.STACK_IN    = '0;
        bus.STACK_VALID = 1'b0;
        bus.TX_READY    = 1'b0;

        // ---- reset state
        #1;
        check_reset_outputs("reset");
        repeat (2) @(negedge CLK_1MHZ);
        RESET = 1'b0;

        // ---- single stack, ready high: latency and full byte sequence
        bus.TX_READY    = 1'b1;
        s               = {16'h0123, 24'h000258, 8'h47};
        bus.STACK_IN    = s;
        bus.STACK_VALID = 1'b1;
        expect_frame(s);
        @(negedge CLK_1MHZ);                      // edge 0 sampled the strobe
        bus.STACK_VALID = 1'b0;
        check("e0_level",    64'(bus.FIFO_LEVEL), 64'(1));
        check("e0_tx_valid", 64'(bus.TX_VALID),   64'(0));
        @(negedge CLK_1MHZ);                      // edge 1 popped it
        check("e1_tx_valid", 64'(bus.TX_VALID),   64'(1));
        check("e1_tx_byte",  64'(bus.TX_BYTE),    64'(8'hAA));
        check("e1_level",    64'(bus.FIFO_LEVEL), 64'(0));
        check("e1_busy",     64'(bus.BUSY),       64'(1));
        repeat (FLEN) @(negedge CLK_1MHZ);
        check("frame_cycles", 64'(got.size()),   64'(FLEN));
        check("end_tx_valid", 64'(bus.TX_VALID), 64'(0));
        check("end_busy",     64'(bus.BUSY),     64'(0));
        compare_stream("single");

        // ---- ready toggling 1,0,0,1: bytes hold while stalled, stream unchanged
        bus.STACK_IN    = s;
        bus.STACK_VALID = 1'b1;
        expect_frame(s);
        for (int i = 0; i < 40; i++) begin
            bus.TX_READY = (i % 4 == 0) || (i % 4 == 3);
            @(negedge CLK_1MHZ);
            bus.STACK_VALID = 1'b0;
        end
        bus.TX_READY = 1'b1;
        wait_idle("stall", 100);
        compare_stream("stall");

        // ---- overflow: ready low, six consecutive strobes
        bus.TX_READY = 1'b0;
        for (int i = 0; i < 7; i++) burst[i] = {16'($urandom()), 32'($urandom())};
        for (int i = 0; i < 6; i++) begin
            bus.STACK_IN    = burst[i];
            bus.STACK_VALID = 1'b1;
            @(negedge CLK_1MHZ);
        end
        bus.STACK_VALID = 1'b0;
        for (int i = 0; i < 5; i++) expect_frame(burst[i]);
        check("ovf_level",   64'(bus.FIFO_LEVEL), 64'(DEPTH));
        check("ovf_flag",    64'(bus.OVERFLOW),   64'(1));
        check("ovf_drops",   64'(bus.DROP_COUNT), 64'(1));
        check("ovf_sync",    64'(bus.TX_BYTE),    64'(8'hAA));
        repeat (5) @(negedge CLK_1MHZ);
        check("ovf_stalled_level", 64'(bus.FIFO_LEVEL), 64'(DEPTH));

        // Release the stall; strobe exactly on the edge where IDLE pops
        bus.TX_READY = 1'b1;
        n = 0;
        while (got.size() < FLEN && n < 4 * FLEN) begin
            @(negedge CLK_1MHZ);
            n++;
        end
        check("first_frame_in_time", 64'(n < 4 * FLEN), 64'(1'b1));
        check("pre_pop_idle",  64'(bus.TX_VALID),   64'(0));
        check("pre_pop_level", 64'(bus.FIFO_LEVEL), 64'(DEPTH));
        bus.STACK_IN    = burst[6];
        bus.STACK_VALID = 1'b1;
        @(negedge CLK_1MHZ);
        bus.STACK_VALID = 1'b0;
        expect_frame(burst[6]);
        check("pop_push_level", 64'(bus.FIFO_LEVEL), 64'(DEPTH));
        check("pop_push_drops", 64'(bus.DROP_COUNT), 64'(1));
        wait_idle("ovf", 200);
        compare_stream("ovf_frames");

        // ---- reset during DATA byte 3 aborts the frame immediately
        s = 48'hDEAD_BEEF_1234;
        bus.STACK_IN    = s;
        bus.STACK_VALID = 1'b1;
        @(negedge CLK_1MHZ);
        bus.STACK_VALID = 1'b0;
        n = 0;
        while (got.size() < 4 && n < 20) begin
            @(negedge CLK_1MHZ);
            n++;
        end
        check("mid_frame_reached", 64'(n < 20), 64'(1'b1));
        check("mid_frame_byte3",   64'(bus.TX_BYTE), 64'(8'hEF));
        #100;
        RESET = 1'b1;
        #1;
        check_reset_outputs("midreset");
        got.delete();
        exp_q.delete();
        @(negedge CLK_1MHZ);
        RESET = 1'b0;
        s = {16'h0123, 24'h000258, 8'h47};
        bus.STACK_IN    = s;
        bus.STACK_VALID = 1'b1;
        expect_frame(s);
        @(negedge CLK_1MHZ);
        bus.STACK_VALID = 1'b0;
        wait_idle("after_reset", 50);
        compare_stream("after_reset");

        // ---- randomized rounds: random stacks, gaps and ready, never enough to drop
        for (int r = 0; r < 6; r++) begin
            k = $urandom_range(1, 4);
            for (int j = 0; j < k; j++) begin
                s = {16'($urandom()), 32'($urandom())};
                expect_frame(s);
                bus.STACK_IN    = s;
                bus.STACK_VALID = 1'b1;
                bus.TX_READY    = 1'($urandom_range(0, 1));
                @(negedge CLK_1MHZ);
                bus.STACK_VALID = 1'b0;
                n = $urandom_range(0, 5);
                for (int g = 0; g < n; g++) begin
                    bus.TX_READY = 1'($urandom_range(0, 1));
                    @(negedge CLK_1MHZ);
                end
            end
            for (int g = 0; g < 30; g++) begin
                bus.TX_READY = 1'($urandom_range(0, 1));
                @(negedge CLK_1MHZ);
            end
            bus.TX_READY = 1'b1;
            wait_idle($sformatf("rand%0d", r), 200);
            compare_stream($sformatf("rand%0d", r));
            check($sformatf("rand%0d_drops", r), 64'(bus.DROP_COUNT), 64'(0));
        end

        // ---- drop counter saturates at 255
        bus.TX_READY = 1'b0;
        for (int i = 0; i < 300; i++) begin
            bus.STACK_IN    = 48'(i);
            bus.STACK_VALID = 1'b1;
            @(negedge CLK_1MHZ);
        end
        bus.STACK_VALID = 1'b0;
        check("sat_drops",    64'(bus.DROP_COUNT), 64'(255));
        check("sat_overflow", 64'(bus.OVERFLOW),   64'(1));
        check("sat_level",    64'(bus.FIFO_LEVEL), 64'(DEPTH));
        RESET = 1'b1;
        #1;
        check_reset_outputs("final_reset");
        @(negedge CLK_1MHZ);
        RESET = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
